// File: rtl/ber_monitor_multi.sv
// Multi-channel bit-error-rate monitor: per-channel lock FSM, counters, snapshot readout.
// Define BER_COUNT_SATURATE_EN to make counters saturate and raise sticky sat_out flags.
module ber_monitor_multi #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 10,
  parameter int ERR_W     = 36,
  parameter int WORD_W    = 48,
  parameter int LOCK_GOOD = 16,
  parameter int LOCK_BAD  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        data_valid,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0]        ref_word,
  input  logic                     snap_req,
  output logic                     snap_ack,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_sel,
  output logic [ERR_W-1:0]         err_count_out,
  output logic [WORD_W-1:0]        word_count_out,
  output logic [NUM_CH-1:0]        lock_out,
  output logic [NUM_CH-1:0]        sat_out
);
  localparam int PC_W    = $clog2(DATA_W + 1);
  localparam int RUN_MAX = (LOCK_GOOD > LOCK_BAD) ? LOCK_GOOD : LOCK_BAD;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] GOOD_LAST = RUN_W'(LOCK_GOOD - 1);
  localparam logic [RUN_W-1:0] BAD_LAST  = RUN_W'(LOCK_BAD - 1);

  typedef enum logic { HUNT, LOCKED } st_e;

  logic [DATA_W-1:0] xor_q    [NUM_CH];
  logic [NUM_CH-1:0] vld_q;
  st_e               st_q     [NUM_CH];
  st_e               st_d     [NUM_CH];
  logic [RUN_W-1:0]  run_q    [NUM_CH];
  logic [RUN_W-1:0]  run_d    [NUM_CH];
  logic [ERR_W-1:0]  err_q    [NUM_CH];
  logic [ERR_W-1:0]  err_d    [NUM_CH];
  logic [WORD_W-1:0] word_q   [NUM_CH];
  logic [WORD_W-1:0] word_d   [NUM_CH];
  logic [NUM_CH-1:0] sat_q, sat_d;
  logic [PC_W-1:0]   pc       [NUM_CH];
  logic [ERR_W-1:0]  sh_err_q [NUM_CH];
  logic [WORD_W-1:0] sh_word_q[NUM_CH];
  logic              pend_q, ack_q, snap_go;
  logic [ERR_W-1:0]  err_out_q;
  logic [WORD_W-1:0] word_out_q;
`ifdef BER_COUNT_SATURATE_EN
  logic [ERR_W:0]    esum     [NUM_CH];
  logic [WORD_W:0]   wsum     [NUM_CH];
`endif

  function automatic logic [PC_W-1:0] popcnt(input logic [DATA_W-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_W; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pc[c]     = popcnt(xor_q[c]);
      st_d[c]   = st_q[c];
      run_d[c]  = run_q[c];
      err_d[c]  = err_q[c];
      word_d[c] = word_q[c];
      sat_d[c]  = sat_q[c];
`ifdef BER_COUNT_SATURATE_EN
      esum[c] = {1'b0, err_q[c]} + (ERR_W + 1)'(pc[c]);
      wsum[c] = {1'b0, word_q[c]} + (WORD_W + 1)'(1);
`endif
      if (vld_q[c]) begin
        unique case (st_q[c])
          HUNT: begin
            if (pc[c] != '0) begin
              run_d[c] = '0;
            end else if (run_q[c] == GOOD_LAST) begin
              st_d[c]  = LOCKED;
              run_d[c] = '0;
            end else begin
              run_d[c] = run_q[c] + 1'b1;
            end
          end
          LOCKED: begin
`ifdef BER_COUNT_SATURATE_EN
            if (esum[c][ERR_W]) begin
              err_d[c] = '1;
              sat_d[c] = 1'b1;
            end else begin
              err_d[c] = esum[c][ERR_W-1:0];
            end
            if (wsum[c][WORD_W]) begin
              word_d[c] = '1;
              sat_d[c]  = 1'b1;
            end else begin
              word_d[c] = wsum[c][WORD_W-1:0];
            end
`else
            err_d[c]  = err_q[c] + ERR_W'(pc[c]);
            word_d[c] = word_q[c] + WORD_W'(1);
`endif
            if (pc[c] == '0) begin
              run_d[c] = '0;
            end else if (run_q[c] == BAD_LAST) begin
              st_d[c]  = HUNT;
              run_d[c] = '0;
            end else begin
              run_d[c] = run_q[c] + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // a new snapshot is refused while the previous copy still awaits its ack
  assign snap_go = snap_req & ~pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        xor_q[c]     <= '0;
        st_q[c]      <= HUNT;
        run_q[c]     <= '0;
        err_q[c]     <= '0;
        word_q[c]    <= '0;
        sh_err_q[c]  <= '0;
        sh_word_q[c] <= '0;
      end
      vld_q      <= '0;
      sat_q      <= '0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_out_q  <= '0;
      word_out_q <= '0;
    end else begin
      if (clear) begin
        for (int c = 0; c < NUM_CH; c++) begin
          xor_q[c]  <= '0;
          st_q[c]   <= HUNT;
          run_q[c]  <= '0;
          err_q[c]  <= '0;
          word_q[c] <= '0;
        end
        vld_q <= '0;
        sat_q <= '0;
      end else if (enable) begin
        for (int c = 0; c < NUM_CH; c++) begin
          xor_q[c]  <= data_in[c*DATA_W +: DATA_W] ^ ref_word;
          st_q[c]   <= st_d[c];
          run_q[c]  <= run_d[c];
          err_q[c]  <= err_d[c];
          word_q[c] <= word_d[c];
        end
        vld_q <= data_valid;
        sat_q <= sat_d;
      end
      if (snap_go) begin
        for (int c = 0; c < NUM_CH; c++) begin
          sh_err_q[c]  <= err_q[c];
          sh_word_q[c] <= word_q[c];
        end
      end
      pend_q <= snap_go;
      ack_q  <= pend_q;
      if (int'(rd_sel) < NUM_CH) begin
        err_out_q  <= sh_err_q[rd_sel];
        word_out_q <= sh_word_q[rd_sel];
      end else begin
        err_out_q  <= '0;
        word_out_q <= '0;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) lock_out[c] = (st_q[c] == LOCKED);
  end

  assign sat_out        = sat_q;
  assign snap_ack       = ack_q;
  assign err_count_out  = err_out_q;
  assign word_count_out = word_out_q;
endmodule

// File: tb/tb_ber_monitor_multi.sv
// Bench for ber_monitor_multi: default-width DUT plus a 4-bit error-counter DUT.
// A per-cycle model checks both; directed scenarios add literal expectations.
module tb_ber_monitor_multi;
  localparam int NCH = 4;
  localparam int DW  = 10;
  localparam int LG  = 16;
  localparam int LB  = 4;
`ifdef BER_COUNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, enable, clear, snap_req;
  logic [3:0]    data_valid;
  logic [39:0]   data_in;
  logic [9:0]    ref_word;
  logic [1:0]    rd_sel;
  logic          snap_ack, snap_ack4;
  logic [35:0]   err_o;
  logic [3:0]    err4_o;
  logic [47:0]   word_o, word4_o;
  logic [3:0]    lock_o, lock4_o, sat_o, sat4_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ber_monitor_multi dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .data_valid(data_valid), .data_in(data_in), .ref_word(ref_word),
    .snap_req(snap_req), .snap_ack(snap_ack), .rd_sel(rd_sel),
    .err_count_out(err_o), .word_count_out(word_o),
    .lock_out(lock_o), .sat_out(sat_o)
  );

  ber_monitor_multi #(.ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .data_valid(data_valid), .data_in(data_in), .ref_word(ref_word),
    .snap_req(snap_req), .snap_ack(snap_ack4), .rd_sel(rd_sel),
    .err_count_out(err4_o), .word_count_out(word4_o),
    .lock_out(lock4_o), .sat_out(sat4_o)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // 4-bit counter view of an unbounded error total
  function automatic int f4(input int v);
    if (SAT) return (v > 15) ? 15 : v;
    return v % 16;
  endfunction

  int         m_err[NCH], m_words[NCH], m_good[NCH], m_bad[NCH];
  int         p_pc[NCH], s_err[NCH], s_words[NCH];
  logic [3:0] m_lock, p_v;
  bit         s_busy, m_ack;
  int         o_err, o_words;
  logic [3:0] exp_sat4;

  task automatic apply(input int i);
    if (m_lock[i]) begin
      m_err[i] += p_pc[i];
      m_words[i]++;
      if (p_pc[i] == 0) m_bad[i] = 0;
      else begin
        m_bad[i]++;
        if (m_bad[i] == LB) begin m_lock[i] = 1'b0; m_bad[i] = 0; end
      end
    end else begin
      if (p_pc[i] != 0) m_good[i] = 0;
      else begin
        m_good[i]++;
        if (m_good[i] == LG) begin m_lock[i] = 1'b1; m_good[i] = 0; end
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_err[i] = 0; m_words[i] = 0; m_good[i] = 0; m_bad[i] = 0; p_pc[i] = 0;
    end
    m_lock = '0;
    p_v    = '0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_clear();
      for (int i = 0; i < NCH; i++) begin s_err[i] = 0; s_words[i] = 0; end
      s_busy = 0; m_ack = 0; o_err = 0; o_words = 0;
    end else begin
      o_err   = s_err[rd_sel];
      o_words = s_words[rd_sel];
      m_ack   = s_busy;
      s_busy  = snap_req && !s_busy;
      if (s_busy)
        for (int i = 0; i < NCH; i++) begin
          s_err[i] = m_err[i]; s_words[i] = m_words[i];
        end
      if (clear) model_clear();
      else if (enable) begin
        for (int i = 0; i < NCH; i++) if (p_v[i]) apply(i);
        for (int i = 0; i < NCH; i++) begin
          p_v[i]  = data_valid[i];
          p_pc[i] = $countones(data_in[i*DW +: DW] ^ ref_word);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) exp_sat4[i] = SAT && (m_err[i] > 15);
      chk("cyc_lock", lock_o, m_lock);
      chk("cyc_lock4", lock4_o, m_lock);
      chk("cyc_sat", sat_o, 0);
      chk("cyc_sat4", sat4_o, exp_sat4);
      chk("cyc_ack", snap_ack, m_ack);
      chk("cyc_ack4", snap_ack4, m_ack);
      chk("cyc_err", err_o, o_err);
      chk("cyc_words", word_o, o_words);
      chk("cyc_err4", err4_o, f4(o_err));
      chk("cyc_words4", word4_o, o_words);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [9:0] e0,
                       input logic [9:0] e1, input logic [9:0] e2,
                       input logic [9:0] e3);
    data_valid = v;
    data_in    = {ref_word ^ e3, ref_word ^ e2, ref_word ^ e1, ref_word ^ e0};
    tick();
    data_valid = '0;
  endtask

  task automatic clean(input logic [3:0] v, input int n);
    repeat (n) drive(v, 10'h0, 10'h0, 10'h0, 10'h0);
  endtask

  task automatic snap(input bit with_clear);
    bit seen;
    seen     = 0;
    snap_req = 1'b1;
    clear    = with_clear;
    tick();
    snap_req   = 1'b0;
    clear      = 1'b0;
    data_valid = '0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (snap_ack) seen = 1;
      else tick();
    end
    chk("snap_ack_seen", seen, 1);
  endtask

  task automatic rd(input logic [1:0] ch, input int e, input int w,
                    input int e4);
    rd_sel = ch;
    tick();
    chk("rd_err", err_o, e);
    chk("rd_words", word_o, w);
    chk("rd_err4", err4_o, e4);
  endtask

  int acks;

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; snap_req = 1'b0;
    data_valid = '0; data_in = '0; ref_word = 10'h2A5; rd_sel = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_err", err_o, 0);
    chk("rst_words", word_o, 0);
    chk("rst_lock", lock_o, 0);
    chk("rst_ack", snap_ack, 0);
    enable = 1'b1;

    clean(4'b0001, 15); tick(); tick();
    chk("ch0_hunt_15", lock_o[0], 0);
    clean(4'b0001, 5); tick(); tick();
    chk("ch0_locked", lock_o[0], 1);
    drive(4'b0001, 10'h001, 0, 0, 0);
    drive(4'b0001, 10'h003, 0, 0, 0);
    drive(4'b0001, 10'h3FF, 0, 0, 0);
    tick(); tick();
    snap(0);
    rd(0, 13, 7, 13);

    ref_word = 10'h13C;
    clean(4'b0010, 16); tick(); tick();
    chk("ch1_locked", lock_o[1], 1);
    drive(4'b0010, 0, 10'h003, 0, 0);
    drive(4'b0010, 0, 10'h007, 0, 0);
    drive(4'b0010, 0, 10'h100, 0, 0);
    tick(); tick();
    chk("ch1_bad3", lock_o[1], 1);
    drive(4'b0010, 0, 10'h00F, 0, 0);
    tick(); tick();
    chk("ch1_bad4", lock_o[1], 0);
    drive(4'b0010, 0, 10'h01F, 0, 0);
    drive(4'b0010, 0, 10'h01F, 0, 0);
    tick(); tick();
    snap(0);
    rd(1, 10, 4, 10);

    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_lock", lock_o, 0);
    clean(4'b0001, 16);
    drive(4'b0001, 10'h01F, 0, 0, 0);
    tick(); tick();
    data_valid = 4'b0001;
    data_in    = {4{ref_word}};
    snap(1);
    rd(0, 5, 1, 5);
    clean(4'b0001, 15); tick(); tick();
    chk("clr_word_dropped", lock_o[0], 0);
    clean(4'b0001, 1); tick(); tick();
    chk("relock", lock_o[0], 1);
    snap(0);
    rd(0, 0, 0, 0);

    clear = 1'b1; tick(); clear = 1'b0;
    ref_word = 10'h0F0;
    clean(4'hF, 16); tick(); tick();
    chk("all_locked", lock_o, 4'hF);
    drive(4'hF, 10'h001, 10'h3FF, 10'h007, 10'h0FF);
    drive(4'hF, 10'h001, 10'h3FF, 10'h000, 10'h0F0);
    tick(); tick();
    chk("sat4_flags", sat4_o, SAT ? 4'b0010 : 4'b0000);
    snap(0);
    rd(0, 2, 2, 2);
    rd(1, 20, 2, SAT ? 15 : 4);
    rd(2, 3, 2, 3);
    rd(3, 12, 2, 12);
    rd_sel = 2'd0;
    #1 chk("rd_latency_old", err_o, 12);
    tick();
    chk("rd_latency_new", err_o, 2);

    enable = 1'b0;
    repeat (3) drive(4'b0001, 10'h3FF, 0, 0, 0);
    snap(0);
    rd(0, 2, 2, 2);
    chk("frozen_lock", lock_o, 4'hF);
    enable = 1'b1;
    tick(); tick(); tick();
    snap(0);
    rd(0, 2, 2, 2);

    snap_req = 1'b1; tick(); tick(); snap_req = 1'b0;
    acks = 0;
    repeat (4) begin
      if (snap_ack) acks++;
      tick();
    end
    chk("held_req_one_ack", acks, 1);

    rd_sel = 2'd1;
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    acks = 0;
    repeat (3) begin
      if (snap_ack) acks++;
      tick();
    end
    chk("rst_abort_ack", acks, 0);
    chk("rst2_err", err_o, 0);
    chk("rst2_words", word_o, 0);
    chk("rst2_lock", lock_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end
endmodule

// File: doc/ber_monitor_multi.md
BER_MONITOR_MULTI -- requirements
Module: ber_monitor_multi

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, number of independent receive channels.
REQ-002 The block SHALL have parameter DATA_W, default 10, word width per channel.
REQ-003 The block SHALL have parameter ERR_W, default 36, bit-error counter width.
REQ-004 The block SHALL have parameter WORD_W, default 48, checked-word counter width.
REQ-005 The block SHALL have parameter LOCK_GOOD, default 16, consecutive clean words needed to lock.
REQ-006 The block SHALL have parameter LOCK_BAD, default 4, consecutive errored words needed to lose lock.
REQ-007 The block SHALL have port clk, input, 1, clock.
REQ-008 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 The block SHALL have port enable, input, 1, global count enable.
REQ-010 The block SHALL have port clear, input, 1, synchronous clear of counters and lock state.
REQ-011 The block SHALL have port data_valid, input, NUM_CH, per-channel word strobe.
REQ-012 The block SHALL have port data_in, input, NUM_CH*DATA_W, channel words, channel 0 in the LSBs.
REQ-013 The block SHALL have port ref_word, input, DATA_W, shared expected word.
REQ-014 The block SHALL have port snap_req, input, 1, snapshot request pulse.
REQ-015 The block SHALL have port snap_ack, output, 1, one-cycle pulse marking the snapshot as complete.
REQ-016 The block SHALL have port rd_sel, input, max(1,$clog2(NUM_CH)), readout channel select.
REQ-017 The block SHALL have port err_count_out, output, ERR_W, snapshot bit errors of the selected channel.
REQ-018 The block SHALL have port word_count_out, output, WORD_W, snapshot checked words of the selected channel.
REQ-019 The block SHALL have port lock_out, output, NUM_CH, live per-channel lock state.
REQ-020 The block SHALL have port sat_out, output, NUM_CH, sticky per-channel saturation flags.

Function
REQ-021 Stage 1 SHALL register, per channel, the value data_in XOR ref_word and data_valid, but only when enable=1.
REQ-022 Stage 2 SHALL compute the popcount of the registered XOR and update that channel's lock FSM and counters; a word SHALL be reflected in the live counters 2 cycles after acceptance.
REQ-023 The per-channel FSM SHALL have two states, HUNT and LOCKED; after reset or clear the FSM SHALL be in HUNT.
REQ-024 In HUNT, LOCK_GOOD consecutive valid words with zero errors SHALL move the FSM to LOCKED; any errored word SHALL restart the run count.
REQ-025 In LOCKED, LOCK_BAD consecutive errored valid words SHALL move the FSM to HUNT; any clean word SHALL restart the run count.
REQ-026 Counters SHALL update only on valid words processed while the FSM is already in LOCKED (pre-update state); the word that causes a transition SHALL count only if the pre-transition state was LOCKED.
REQ-027 For each counted word, word_count SHALL increment by 1 and err_count SHALL increase by the popcount (0..DATA_W).
REQ-028 Cycles with data_valid=0 SHALL leave the run counts unchanged.
REQ-029 When snap_req=1, the next edge SHALL copy all live counters into shadow registers, and snap_ack SHALL pulse on the cycle after that copy.
REQ-030 A snap_req arriving while a snapshot is in progress SHALL be ignored.
REQ-031 err_count_out and word_count_out SHALL be a registered mux of the shadow registers selected by rd_sel, with 1-cycle latency.
REQ-032 clear SHALL zero the live counters, the run counts, the sat flags and the stage-1 registers, and SHALL set all FSMs to HUNT; it SHALL NOT alter the shadow registers.
REQ-033 If clear and snap_req are asserted in the same cycle, the shadow registers SHALL capture the pre-clear values.
REQ-034 If clear coincides with a valid word, clear SHALL win and the word SHALL be discarded.
REQ-035 enable=0 SHALL freeze stage 1, the FSMs and the counters; snapshot and readout SHALL remain functional.

Reset
REQ-036 rst SHALL asynchronously zero all counters, shadows, run counts, pipeline registers, snap_ack, err_count_out, word_count_out, lock_out and sat_out, and SHALL force every FSM to HUNT.
REQ-037 Assertion of rst mid-snapshot SHALL abort the snapshot with no snap_ack.

Configuration
REQ-038 With macro BER_COUNT_SATURATE_EN defined, each counter SHALL hold at all-ones instead of wrapping, and the channel's sat_out SHALL set and stay set until clear or rst.
REQ-039 Without BER_COUNT_SATURATE_EN, counters SHALL wrap modulo 2^width and sat_out SHALL be constant 0.

Verification
REQ-040 Drive ch0 with 20 clean words, then 3 words with 1, 2 and 10 bit errors, then snap -> LOCKED after word 16; snapshot err=13, words=7.
REQ-041 Drive ch1 in LOCKED with 4 consecutive errored words -> lock_out[1] falls after the 4th word; the 4th word's errors are counted and later words are not.
REQ-042 Assert clear and snap_req in the same cycle with ch0 err=5 -> shadow err=5; live counters read 0 on the next snap.
REQ-043 With ERR_W=4, BER_COUNT_SATURATE_EN defined, and 20 errored bits accumulated -> err=15 and sat_out=1; with the macro undefined -> err=4 and sat_out=0.
REQ-044 Feed all 4 channels different error patterns simultaneously, snap, then sweep rd_sel 0..3 -> each output matches its channel's count with 1-cycle latency.
